// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - collects sample frames, sequences the FFT core and captures its spectrum
// Optional dropped-frame counter output enabled by FFT_FRAME_CTRL_DROP_CNT_EN.
module fft_frame_ctrl #(
  parameter int WIDTH       = 12,
  parameter int N           = 16,
  parameter int CAPTURE_DLY = 3,
  parameter int TIMEOUT     = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_in,
  output logic             fft_rst,
  output logic             fft_start,
  input  logic             fft_done,
  output logic [WIDTH-1:0] time_samples [0:N-1],
  input  logic [WIDTH-1:0] freq_samples [0:N-1],
  output logic [WIDTH-1:0] spec_out [0:N-1],
  output logic             spec_valid,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err
`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SET_W  = (CAPTURE_DLY > 1) ? $clog2(CAPTURE_DLY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_START,
    S_WAIT,
    S_SETTLE,
    S_CAPTURE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   wr_idx;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [WIDTH-1:0]   collect [0:N-1];
  logic               wr_last;
  logic               frame_full;
  logic               dropping;
  logic               settle_last;
  logic               tout_hit;
  logic               capture_now;

  assign wr_last     = (wr_idx == IDX_W'(N - 1));
  assign frame_full  = sample_valid && !rst && wr_last;
  assign dropping    = frame_full && (state != S_IDLE);
  assign settle_last = (int'(settle_cnt) >= CAPTURE_DLY - 1);
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_nxt   = state;
    fft_rst     = rst;
    fft_start   = 1'b0;
    tout_hit    = 1'b0;
    capture_now = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_full) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        fft_rst   = 1'b1;
        state_nxt = S_START;
      end
      S_START: begin
        fft_start = !rst;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (fft_done) begin
          state_nxt = S_SETTLE;
        end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
          tout_hit  = 1'b1;
          fft_rst   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (settle_last) begin
          capture_now = 1'b1;
          state_nxt   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Collect buffer needs no reset: a partial frame is discarded by clearing wr_idx.
  always_ff @(posedge clk) begin
    if (!rst && sample_valid) collect[wr_idx] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_idx      <= '0;
      wait_cnt    <= '0;
      settle_cnt  <= '0;
      spec_valid  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        time_samples[i] <= '0;
        spec_out[i]     <= '0;
      end
    end else begin
      state <= state_nxt;
      if (sample_valid) wr_idx <= wr_last ? '0 : wr_idx + IDX_W'(1);

      // The last sample bypasses the buffer so the hold copy is complete this cycle.
      if (frame_full && state == S_IDLE) begin
        for (int i = 0; i < N; i++) begin
          time_samples[i] <= (i == N - 1) ? sample_in : collect[i];
        end
      end
      if (dropping) overrun <= 1'b1;
      if (tout_hit) timeout_err <= 1'b1;

      wait_cnt   <= (state == S_WAIT && state_nxt == S_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      settle_cnt <= (state == S_SETTLE && state_nxt == S_SETTLE) ? settle_cnt + SET_W'(1) : '0;

      // Spectrum is latched on entry to CAPTURE so spec_out and spec_valid change together.
      spec_valid <= capture_now;
      if (capture_now) begin
        for (int i = 0; i < N; i++) spec_out[i] <= freq_samples[i];
      end
    end
  end

`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (dropping && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - self-checking bench for fft_frame_ctrl with event-schedule model and FFT core model
module tb_fft_frame_ctrl;
  localparam int W   = 12;
  localparam int N   = 16;
  localparam int CD  = 3;
  localparam int TO  = 15;
  localparam int TO2 = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, sample_valid, fft_rst, fft_start, fft_done;
  logic [W-1:0] sample_in;
  logic [W-1:0] time_samples [0:N-1];
  logic [W-1:0] freq_samples [0:N-1];
  logic [W-1:0] spec_out [0:N-1];
  logic         spec_valid, busy, overrun, timeout_err;

  logic         sv_b, fft_rst_b, fft_start_b, fft_done_b;
  logic [W-1:0] si_b;
  logic [W-1:0] time_b [0:N-1];
  logic [W-1:0] freq_b [0:N-1];
  logic [W-1:0] spec_b [0:N-1];
  logic         spec_valid_b, busy_b, overrun_b, timeout_err_b;
`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
  logic [15:0]  drop_cnt, drop_cnt_b;
`endif

  fft_frame_ctrl #(.WIDTH(W), .N(N), .CAPTURE_DLY(CD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .fft_rst(fft_rst), .fft_start(fft_start), .fft_done(fft_done),
    .time_samples(time_samples), .freq_samples(freq_samples), .spec_out(spec_out),
    .spec_valid(spec_valid), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  fft_frame_ctrl #(.WIDTH(W), .N(N), .CAPTURE_DLY(CD), .TIMEOUT(TO2)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sv_b), .sample_in(si_b),
    .fft_rst(fft_rst_b), .fft_start(fft_start_b), .fft_done(fft_done_b),
    .time_samples(time_b), .freq_samples(freq_b), .spec_out(spec_b),
    .spec_valid(spec_valid_b), .busy(busy_b), .overrun(overrun_b), .timeout_err(timeout_err_b)
`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
    , .drop_cnt(drop_cnt_b)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic check_arr(input string name, input logic [W-1:0] a [0:N-1], input logic [W-1:0] b [0:N-1]);
    int bad;
    bad = -1;
    for (int i = N - 1; i >= 0; i--) if (a[i] !== b[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at cycle %0d", name, bad, a[bad], b[bad], cyc);
    end
  endtask

  // FFT core model: done level fft_dly cycles after start (never when negative); result = reversed frame ^ A5A.
  int fft_dly = 2;
  int f_start_cyc = 0;
  bit f_pend = 0;
  initial begin
    fft_done = 1'b0;
    for (int i = 0; i < N; i++) freq_samples[i] = '0;
    forever begin
      @(posedge clk);
      #2;
      if (fft_rst === 1'b1) begin
        fft_done = 1'b0;
        f_pend   = 0;
      end else if (fft_start === 1'b1) begin
        fft_done    = 1'b0;
        f_pend      = 1;
        f_start_cyc = cyc;
        for (int i = 0; i < N; i++) freq_samples[i] = time_samples[N-1-i] ^ 12'hA5A;
      end else if (f_pend && fft_dly >= 0 && cyc >= f_start_cyc + fft_dly) begin
        fft_done = 1'b1;
      end
    end
  end

  // Controller model: each accepted frame schedules its FLUSH/START/valid/timeout cycles.
  bit           chk_en = 0;
  bit           m_job = 0, m_ovr = 0, m_terr = 0, busy_now = 0, terr_prev = 0;
  int           m_wr = 0, m_drop = 0;
  int           t_flush = -10, t_start = -10, t_valid = -10, t_end = -10, t_tout = -10;
  int           start_seen = 0, sv_seen = 0, sv_count = 0, terr_rise = 0, last_full = 0;
  logic [W-1:0] m_coll [0:N-1];
  logic [W-1:0] m_hold [0:N-1];
  logic [W-1:0] m_spec [0:N-1];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_coll[i] = '0;
      m_hold[i] = '0;
      m_spec[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("busy", busy, 32'(m_job && cyc >= t_flush && cyc <= t_end));
        check("fft_rst", fft_rst, 32'(rst || (m_job && (cyc == t_flush || cyc == t_tout))));
        check("fft_start", fft_start, 32'(m_job && cyc == t_start && !rst));
        check("spec_valid", spec_valid, 32'(m_job && cyc == t_valid));
        check("overrun", overrun, 32'(m_ovr));
        check("timeout_err", timeout_err, 32'(m_terr));
        check_arr("time_samples", time_samples, m_hold);
        check_arr("spec_out", spec_out, m_spec);
`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
        check("drop_cnt", drop_cnt, 32'(m_drop));
`endif
      end
      if (fft_start === 1'b1) start_seen = cyc;
      if (spec_valid === 1'b1) begin
        sv_count++;
        sv_seen = cyc;
      end
      if (timeout_err === 1'b1 && !terr_prev) terr_rise = cyc;
      terr_prev = (timeout_err === 1'b1);

      if (rst) begin
        m_job = 0; m_wr = 0; m_ovr = 0; m_terr = 0; m_drop = 0;
        for (int i = 0; i < N; i++) begin
          m_hold[i] = '0;
          m_spec[i] = '0;
        end
      end else begin
        busy_now = m_job;
        if (m_job && cyc == t_valid - 1) begin
          for (int i = 0; i < N; i++) m_spec[i] = m_hold[N-1-i] ^ 12'hA5A;
        end
        if (m_job && cyc == t_end) begin
          m_job = 0;
          if (cyc == t_tout) m_terr = 1;
        end
        if (sample_valid) begin
          m_coll[m_wr] = sample_in;
          if (m_wr == N - 1) begin
            last_full = cyc;
            if (!busy_now) begin
              m_hold  = m_coll;
              m_job   = 1;
              t_flush = cyc + 1;
              t_start = cyc + 2;
              if (fft_dly >= 0) begin
                t_valid = t_start + fft_dly + CD + 1;
                t_end   = t_valid;
                t_tout  = -10;
              end else begin
                t_valid = -10;
                t_tout  = t_start + 1 + TO;
                t_end   = t_tout;
              end
            end else begin
              m_ovr = 1;
              if (m_drop < 65535) m_drop++;
            end
          end
          m_wr = (m_wr + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int val, input int gap);
    sample_valid = 1'b1;
    sample_in    = W'(val);
    tick();
    sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int n = 0; n < budget && busy !== 1'b0; n++) tick();
    check(name, busy, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    sv_b = 1'b0; si_b = '0; fft_done_b = 1'b0;
    for (int i = 0; i < N; i++) freq_b[i] = '0;
    tick();
    chk_en = 1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_busy", busy, 0);
    check("reset_spec_valid", spec_valid, 0);
    check("reset_time0", time_samples[0], 0);

    // basic frame, back-to-back samples
    for (int v = 0; v < N; v++) send(v, 0);
    wait_idle("basic_idle", 60);
    check("basic_start_lat", start_seen - last_full, 2);
    check("basic_valid_lat", sv_seen - start_seen, 6);
    check("basic_sv_count", sv_count, 1);
    check("basic_time5", time_samples[5], 5);
    check("basic_spec0", spec_out[0], 12'hA55);
    check("basic_spec15", spec_out[15], 12'hA5A);

    // gapped frame, 1-in-4 valid
    for (int v = 0; v < N; v++) send(v, 3);
    wait_idle("gap_idle", 60);
    check("gap_sv_count", sv_count, 2);
    check("gap_spec0", spec_out[0], 12'hA55);
    check("gap_spec3", spec_out[3], 12'hA56);

    // FFT never completes
    fft_dly = -1;
    for (int v = 0; v < N; v++) send(100 + v, 0);
    wait_idle("tout_idle", 60);
    check("tout_err", timeout_err, 1);
    check("tout_lat", terr_rise - start_seen, TO + 2);
    check("tout_sv_count", sv_count, 2);
    check("tout_time0", time_samples[0], 100);

    // reset while in SETTLE
    fft_dly = 2;
    for (int v = 0; v < N; v++) send(200 + v, 0);
    repeat (4) tick();
    check("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_err", timeout_err, 0);
    check("rstmid_time3", time_samples[3], 0);
    check("rstmid_start", fft_start, 0);
    repeat (10) tick();
    check("rstmid_sv_count", sv_count, 2);
    for (int v = 0; v < N; v++) send(300 + v, 0);
    wait_idle("rstmid_idle", 60);
    check("rstmid_next_sv", sv_count, 3);
    check("rstmid_next_time0", time_samples[0], 300);
    check("rstmid_next_spec0", spec_out[0], 12'hB61);

    // frame_full lands on the CAPTURE cycle
    fft_dly = 12;
    for (int v = 0; v < N; v++) send(400 + v, 0);
    tick(); tick();
    for (int v = 0; v < N; v++) send(500 + v, 0);
    wait_idle("bound_idle", 60);
    check("bound_coincide", sv_seen - last_full, 0);
    check("bound_sv_count", sv_count, 4);
    check("bound_overrun", overrun, 1);
    check("bound_time0", time_samples[0], 400);
    check("bound_spec0", spec_out[0], 12'hBC5);
`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
    check("bound_drop_cnt", drop_cnt, 1);
`endif

    // 32 fast samples into a never-done core with TIMEOUT=100
    for (int v = 0; v < 2 * N; v++) begin
      sv_b = 1'b1;
      si_b = W'(v);
      tick();
    end
    sv_b = 1'b0;
    tick();
    check("ovr_overrun", overrun_b, 1);
    check("ovr_busy", busy_b, 1);
    check("ovr_time0", time_b[0], 0);
    check("ovr_time15", time_b[15], 15);
    check("ovr_tout", timeout_err_b, 0);
    check("ovr_spec_valid", spec_valid_b, 0);
`ifdef FFT_FRAME_CTRL_DROP_CNT_EN
    check("ovr_drop_cnt", drop_cnt_b, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
